// File: rtl/python_frame_sequencer_pkg.sv
// Shared types and constants for the Python sensor frame sequencer.
// Holds FSM states, the default minimum blank and the config word width.
package python_frame_sequencer_pkg;

    localparam int CFG_W         = 16;
    localparam int MIN_BLANK_DEF = 4;

    typedef logic [CFG_W-1:0] cfg_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_VBLANK,
        S_WAIT_TRIG,
        S_LINE,
        S_HBLANK
    } state_e;

    typedef struct packed {
        cfg_t width;
        cfg_t lines;
        cfg_t hblank;
        cfg_t vblank;
    } geom_t;

    function automatic cfg_t clamp_blank(cfg_t v, cfg_t min_v);
        return (v < min_v) ? min_v : v;
    endfunction

endpackage

// File: rtl/python_frame_sequencer_if.sv
// Config inputs and video timing outputs of the frame sequencer.
// master = sequencer side, slave = consumer/driver side.
interface python_frame_sequencer_if
    import python_frame_sequencer_pkg::*;
#(
    parameter int PIX_W = 32
);
    logic             i_stream_en;
    logic             i_trigger;
    cfg_t             iv_line_width;
    cfg_t             iv_frame_lines;
    cfg_t             iv_hblank;
    cfg_t             iv_vblank;
    logic             o_init_done;
    logic             o_fval;
    logic             o_lval;
    logic [PIX_W-1:0] ov_pix_data;
    cfg_t             ov_frame_cnt;

    modport master (
        input  i_stream_en, i_trigger,
        input  iv_line_width, iv_frame_lines, iv_hblank, iv_vblank,
        output o_init_done, o_fval, o_lval, ov_pix_data, ov_frame_cnt
    );

    modport slave (
        output i_stream_en, i_trigger,
        output iv_line_width, iv_frame_lines, iv_hblank, iv_vblank,
        input  o_init_done, o_fval, o_lval, ov_pix_data, ov_frame_cnt
    );
endinterface

// File: rtl/python_pattern_gen.sv
// Registered test pattern: channel c of beat p on line l = l + p*CH + c.
// Inputs are next-cycle values so the output lines up with lval.
module python_pattern_gen
    import python_frame_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNEL_NUM = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            i_lval,
    input  cfg_t                            iv_line,
    input  cfg_t                            iv_beat,
    output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data
);
    logic [DATA_WIDTH*CHANNEL_NUM-1:0] pix_d, pix_q;

    always_comb begin
        pix_d = '0;
        if (i_lval) begin
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                pix_d[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(
                    iv_line + iv_beat * cfg_t'(CHANNEL_NUM) + cfg_t'(c));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pix_q <= '0;
        else          pix_q <= pix_d;
    end

    assign ov_pix_data = pix_q;

endmodule

// File: rtl/python_frame_sequencer.sv
// Frame/line timing master with per-frame shadowed geometry.
// Optional PYTHON_TRIG_EN: each frame waits for an i_trigger pulse.
module python_frame_sequencer
    import python_frame_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNEL_NUM = 4,
    parameter int INIT_CYCLES = 1024,
    parameter int MIN_BLANK   = MIN_BLANK_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    python_frame_sequencer_if.master bus
);
    localparam cfg_t INIT_LAST = cfg_t'(INIT_CYCLES);
    localparam cfg_t MIN_B     = cfg_t'(MIN_BLANK);

    state_e state_q, state_d;
    cfg_t   cnt_q, cnt_d;
    cfg_t   beat_q, beat_d;
    cfg_t   line_q, line_d;
    cfg_t   fcnt_q, fcnt_d;
    geom_t  sh_q, sh_d;
    logic   done_q, done_d;
    logic   go_line;
    geom_t  cfg_in;
    cfg_t   vb_last, hb_last;
    logic   geom_ok;
    logic   trig_hit;

`ifdef PYTHON_TRIG_EN
    logic trig_q, trig_d;
    assign trig_hit = trig_q | bus.i_trigger;
`else
    assign trig_hit = 1'b1;
`endif

    assign cfg_in  = '{bus.iv_line_width, bus.iv_frame_lines,
                       bus.iv_hblank, bus.iv_vblank};
    assign vb_last = clamp_blank(sh_q.vblank, MIN_B) - 16'd1;
    assign hb_last = clamp_blank(sh_q.hblank, MIN_B) - 16'd1;
    assign geom_ok = (sh_q.width != '0) && (sh_q.lines != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        line_d  = line_q;
        fcnt_d  = fcnt_q;
        sh_d    = sh_q;
        done_d  = done_q;
        go_line = 1'b0;
        unique case (state_q)
            S_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_IDLE: begin
                if (bus.i_stream_en) begin
                    state_d = S_VBLANK;
                    sh_d    = cfg_in;
                    cnt_d   = '0;
                end
            end
            S_VBLANK: begin
                if (cnt_q == vb_last) begin
                    cnt_d = '0;
                    // empty geometry: keep blanking and re-sample config
                    if (!geom_ok) begin
                        if (bus.i_stream_en) sh_d = cfg_in;
                        else                 state_d = S_IDLE;
                    end else if (trig_hit) begin
                        go_line = 1'b1;
                    end else begin
                        state_d = S_WAIT_TRIG;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT_TRIG: begin
                if (trig_hit) go_line = 1'b1;
            end
            S_LINE: begin
                if (beat_q == sh_q.width - 16'd1) begin
                    beat_d = '0;
                    cnt_d  = '0;
                    if (line_q == sh_q.lines - 16'd1) begin
                        line_d = '0;
                        fcnt_d = fcnt_q + 16'd1;
                        if (bus.i_stream_en) begin
                            state_d = S_VBLANK;
                            sh_d    = cfg_in;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        line_d  = line_q + 16'd1;
                        state_d = S_HBLANK;
                    end
                end else begin
                    beat_d = beat_q + 16'd1;
                end
            end
            S_HBLANK: begin
                if (cnt_q == hb_last) begin
                    cnt_d   = '0;
                    state_d = S_LINE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_INIT;
        endcase
        if (go_line) begin
            state_d = S_LINE;
            beat_d  = '0;
            line_d  = '0;
        end
    end

`ifdef PYTHON_TRIG_EN
    // one pending trigger, only collected while blanking before a frame
    always_comb begin
        trig_d = (state_q == S_VBLANK) && (trig_q || bus.i_trigger);
        if (go_line) trig_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) trig_q <= 1'b0;
        else          trig_q <= trig_d;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            fcnt_q  <= '0;
            sh_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            fcnt_q  <= fcnt_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
        end
    end

    python_pattern_gen #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CHANNEL_NUM (CHANNEL_NUM)
    ) u_pattern (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_lval      (state_d == S_LINE),
        .iv_line     (line_d),
        .iv_beat     (beat_d),
        .ov_pix_data (bus.ov_pix_data)
    );

    assign bus.o_init_done  = done_q;
    assign bus.o_fval       = (state_q == S_LINE) || (state_q == S_HBLANK);
    assign bus.o_lval       = (state_q == S_LINE);
    assign bus.ov_frame_cnt = fcnt_q;

endmodule

// File: tb/tb_python_frame_sequencer.sv
// Scoreboard bench: frame records and pixel words are queued by the stimulus
// and checked by a negedge monitor as the sequencer emits them.
module tb_python_frame_sequencer;

    localparam int DW   = 8;
    localparam int CH   = 4;
    localparam int INIT = 16;
    localparam int MINB = 4;

    typedef struct {
        int vb;
        int w;
        int lines;
        int hb;
        int fcnt;
    } fexp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fexp_t       fq[$];
    logic [31:0] pq[$];

    python_frame_sequencer_if #(.PIX_W(DW*CH)) bus ();

    python_frame_sequencer #(
        .DATA_WIDTH  (DW),
        .CHANNEL_NUM (CH),
        .INIT_CYCLES (INIT),
        .MIN_BLANK   (MINB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input int n);
        checks++;
        errors++;
        $display("FAIL %s: condition not met after %0d cycles", nm, n);
    endtask

    function automatic int clampb(input int v);
        return (v < MINB) ? MINB : v;
    endfunction

    function automatic logic [31:0] pixw(input int l, input int p);
        logic [31:0] w;
        w = '0;
        for (int c = 0; c < CH; c++) w[c*DW +: DW] = DW'((l + p*CH + c) % 256);
        return w;
    endfunction

    task automatic push_frame(input int w, input int l, input int hb,
                              input int vb, input int fc);
        fexp_t e;
        for (int li = 0; li < l; li++)
            for (int p = 0; p < w; p++) pq.push_back(pixw(li, p));
        e.vb    = (vb < 0) ? -1 : clampb(vb);
        e.w     = w;
        e.lines = l;
        e.hb    = clampb(hb);
        e.fcnt  = fc;
        fq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int w, input int l, input int hb, input int vb);
        bus.iv_line_width  = 16'(w);
        bus.iv_frame_lines = 16'(l);
        bus.iv_hblank      = 16'(hb);
        bus.iv_vblank      = 16'(vb);
    endtask

    task automatic pulse_trig();
        bus.i_trigger = 1'b1;
        tick(1);
        bus.i_trigger = 1'b0;
    endtask

    task automatic start();
        bus.i_stream_en = 1'b1;
        tick(1);
        pulse_trig();
    endtask

    task automatic wait_lval_rises(input int n, input int budget);
        int   k = 0;
        int   got = 0;
        logic p = bus.o_lval;
        while (got < n && k < budget) begin
            tick(1);
            k++;
            if (bus.o_lval && !p) got++;
            p = bus.o_lval;
        end
        if (got < n) fail_now("lval_rise_timeout", k);
    endtask

    task automatic wait_fval_fall(input int budget);
        int   k = 0;
        logic p = bus.o_fval;
        while (!(p && !bus.o_fval) && k < budget) begin
            p = bus.o_fval;
            tick(1);
            k++;
        end
        if (k >= budget) fail_now("fval_fall_timeout", k);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while ((fq.size() != 0 || pq.size() != 0 || bus.o_fval) && k < budget) begin
            tick(1);
            k++;
        end
        if (k >= budget) fail_now("frame_done_timeout", k);
        tick(3);
    endtask

    // monitor: frame timing, pixel stream, frame counter
    initial begin
        logic  f, l, pf, pl, pe;
        int    gap, flen, lcnt, lw, hc;
        bit    have;
        fexp_t e;
        pf = 0; pl = 0; pe = 0;
        gap = 0; flen = 0; lcnt = 0; lw = 0; hc = 0; have = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pf = 0; pl = 0; pe = 0; have = 0;
            end else begin
                f = bus.o_fval;
                l = bus.o_lval;
                if (!f) chk("lval_in_vblank", l, 0);
                if (!l) chk("pix_blank", bus.ov_pix_data, 0);
                if (f && !pf) begin
                    if (fq.size() == 0) begin
                        checks++;
                        errors++;
                        have = 0;
                        $display("FAIL spurious_frame: fval rose, frame_cnt %0d, none expected",
                                 bus.ov_frame_cnt);
                    end else begin
                        e = fq.pop_front();
                        have = 1;
                        if (e.vb >= 0) chk("vblank_len", gap, e.vb);
                        chk("first_lval_edge", l, 1);
                    end
                    flen = 0; lcnt = 0; lw = 0; hc = 0;
                end
                if (f) begin
                    flen++;
                    if (l) begin
                        if (!pl) begin
                            lcnt++;
                            if (have && lcnt > 1) chk("hblank_len", hc, e.hb);
                            lw = 0;
                        end
                        lw++;
                        if (pq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL pix_underflow: got %0h expected none",
                                     bus.ov_pix_data);
                        end else begin
                            chk("pix", bus.ov_pix_data, pq.pop_front());
                        end
                    end else begin
                        if (pl) begin
                            if (have) chk("lval_width", lw, e.w);
                            hc = 1;
                        end else begin
                            hc++;
                        end
                    end
                end
                if (!f && pf) begin
                    gap = 1;
                    if (have) begin
                        chk("last_lval_edge", pl, 1);
                        if (pl) chk("lval_width", lw, e.w);
                        chk("fval_len", flen, e.w*e.lines + e.hb*(e.lines-1));
                        chk("line_count", lcnt, e.lines);
                        chk("frame_cnt", bus.ov_frame_cnt, e.fcnt);
                    end
                    have = 0;
                end else if (!f) begin
                    gap++;
                end
                if (bus.i_stream_en && !pe && !f) gap = 0;
                pf = f;
                pl = l;
                pe = bus.i_stream_en;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_stream_en = 1'b0;
        bus.i_trigger   = 1'b0;
        set_cfg(0, 0, 0, 0);
        #8;
        chk("rst_fval", bus.o_fval, 0);
        chk("rst_lval", bus.o_lval, 0);
        chk("rst_pix", bus.ov_pix_data, 0);
        chk("rst_fcnt", bus.ov_frame_cnt, 0);
        chk("rst_init_done", bus.o_init_done, 0);
        #4 reset_n = 1'b1;

        // init window: done rises on clock INIT+1
        repeat (INIT) @(posedge clk);
        #1 chk("init_done_early", bus.o_init_done, 0);
        tick(1);
        chk("init_done", bus.o_init_done, 1);
        tick(30);
        chk("idle_fval", bus.o_fval, 0);

        // basic frame
        set_cfg(8, 3, 5, 6);
        push_frame(8, 3, 5, 6, 1);
        start();
        wait_lval_rises(1, 100);
        bus.i_stream_en = 1'b0;
        pulse_trig();
        tick(3);
        pulse_trig();
        wait_done(300);

        // clamped blanks, back-to-back frames, shadowed hblank change
        set_cfg(8, 3, 1, 0);
        push_frame(8, 3, 1, 0, 2);
        start();
        wait_lval_rises(1, 100);
        set_cfg(8, 3, 7, 0);
        push_frame(8, 3, 7, 0, 3);
        wait_fval_fall(200);
        pulse_trig();
        wait_lval_rises(1, 100);
        bus.i_stream_en = 1'b0;
        wait_done(300);

        // pixel wrap across 256
        set_cfg(64, 3, 4, 4);
        push_frame(64, 3, 4, 4, 4);
        start();
        wait_lval_rises(1, 100);
        bus.i_stream_en = 1'b0;
        wait_done(1000);

        // stop and width change mid-frame
        set_cfg(5, 3, 4, 5);
        push_frame(5, 3, 4, 5, 5);
        start();
        wait_lval_rises(2, 200);
        bus.iv_line_width = 16'd9;
        bus.i_stream_en   = 1'b0;
        wait_done(300);
        tick(60);
        chk("stopped_fval", bus.o_fval, 0);

        // zero width keeps reloading, then a one-line frame
        set_cfg(0, 2, 4, 4);
        start();
        tick(40);
        chk("zero_width_fval", bus.o_fval, 0);
        set_cfg(4, 1, 4, 4);
        push_frame(4, 1, 4, -1, 6);
        wait_lval_rises(1, 100);
        bus.i_stream_en = 1'b0;
        wait_done(200);

`ifdef PYTHON_TRIG_EN
        // no trigger holds the frame off
        set_cfg(4, 2, 4, 4);
        bus.i_stream_en = 1'b1;
        tick(40);
        chk("no_trig_fval", bus.o_fval, 0);
        push_frame(4, 2, 4, -1, 7);
        pulse_trig();
        wait_lval_rises(1, 50);
        bus.i_stream_en = 1'b0;
        wait_done(200);
`endif

        tick(5);
        chk("queues_empty", fq.size() + pq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
